regfile_access_scheduler: RTL and testbench

// Sequences all traffic into the 16x32 FP register stack: issues operand reads
// for the issue stage and arbitrates its single (optionally paired) write port

---
 rtl/regfile_access_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_regfile_access_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_access_scheduler
//
// Sequences all traffic into the 16x32 FP register stack. It issues operand
// reads for the issue stage. It arbitrates the single write port, which can
// optionally write a pair of registers, between two requesters:
//   A = FP ALU writeback
//   B = load/host path
// A pending-write scoreboard blocks two kinds of issue while a write is in
// flight on a register:
//   - RAW: the instruction reads that register.
//   - WAW: the instruction writes that register.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   flush_i                  clear scoreboard, block every grant this cycle
//   rd_req_i                 issue request (held until rd_gnt_o)
//   rd_src1_i, rd_src2_i     source register addresses
//   rd_dst_i, rd_pair_i      destination register / also writes dst+1
//   rd_gnt_o                 combinational issue grant
//   {a,b}_wr_req_i           write request (held until grant)
//   {a,b}_wr_ad_i            write address
//   {a,b}_wr_pair_i          also write val2 to ad+1
//   {a,b}_wr_val_i/val2_i    write data
//   {a,b}_wr_gnt_o           combinational write grant
//   rd_en_o                  reg stack read enable
//   reg_src1_ad_o/2_ad_o     reg stack read addresses
//   wrt_en_o, reg2_wr_en_o   reg stack write enable / second-register enable
//   reg_out_ad_o             reg stack write address
//   reg_wrt_val_o/val2_o     reg stack write data
//   pend_o                   scoreboard; bit i = write to reg i outstanding
//   stall_cnt_o              saturating count of stalled issue cycles
// -----------------------------------------------------------------------------
module regfile_access_scheduler #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG),
  parameter int DW   = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,

  input  logic            rd_req_i,
  input  logic [AW-1:0]   rd_src1_i,
  input  logic [AW-1:0]   rd_src2_i,
  input  logic [AW-1:0]   rd_dst_i,
  input  logic            rd_pair_i,
  output logic            rd_gnt_o,

  input  logic            a_wr_req_i,
  input  logic [AW-1:0]   a_wr_ad_i,
  input  logic            a_wr_pair_i,
  input  logic [DW-1:0]   a_wr_val_i,
  input  logic [DW-1:0]   a_wr_val2_i,
  output logic            a_wr_gnt_o,

  input  logic            b_wr_req_i,
  input  logic [AW-1:0]   b_wr_ad_i,
  input  logic            b_wr_pair_i,
  input  logic [DW-1:0]   b_wr_val_i,
  input  logic [DW-1:0]   b_wr_val2_i,
  output logic            b_wr_gnt_o,

  output logic            rd_en_o,
  output logic [AW-1:0]   reg_src1_ad_o,
  output logic [AW-1:0]   reg_src2_ad_o,
  output logic            wrt_en_o,
  output logic            reg2_wr_en_o,
  output logic [AW-1:0]   reg_out_ad_o,
  output logic [DW-1:0]   reg_wrt_val_o,
  output logic [DW-1:0]   reg_wrt_val2_o,
  output logic [NREG-1:0] pend_o,
  output logic [15:0]     stall_cnt_o
);

  // State registers
  logic [NREG-1:0] pend_q, pend_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic            prefer_b_q, prefer_b_d;   // 0: A wins a tie
  logic            rd_en_q;
  logic [AW-1:0]   src1_ad_q, src1_ad_d;
  logic [AW-1:0]   src2_ad_q, src2_ad_d;
  logic            wrt_en_q;
  logic            reg2_wr_en_q, reg2_wr_en_d;
  logic [AW-1:0]   out_ad_q, out_ad_d;
  logic [DW-1:0]   wrt_val_q, wrt_val_d;
  logic [DW-1:0]   wrt_val2_q, wrt_val2_d;

  // Combinational datapath
  logic            rd_gnt, a_gnt, b_gnt, wr_gnt;
  logic [AW-1:0]   dst_p1;
  logic [AW-1:0]   win_ad, win_ad_p1;
  logic            win_pair;
  logic [DW-1:0]   win_val, win_val2;
  logic [NREG-1:0] set_mask, clr_mask;

  // The +1 is truncated to AW bits, so register 15 pairs with register 0.
  assign dst_p1 = rd_dst_i + 1'b1;

  // Grants look only at registered pend. A write that clears a bit this cycle
  // therefore unblocks a dependent issue on the following cycle at the earliest.
  // Every grant is held low while reset is asserted.
  assign rd_gnt = rst_ni & rd_req_i & ~flush_i
                & ~pend_q[rd_src1_i] & ~pend_q[rd_src2_i] & ~pend_q[rd_dst_i]
                & ~(rd_pair_i & pend_q[dst_p1]);

  // Round-robin: a lone requester always wins; on a tie the pointer decides.
  assign a_gnt  = rst_ni & ~flush_i & a_wr_req_i & (~b_wr_req_i | ~prefer_b_q);
  assign b_gnt  = rst_ni & ~flush_i & b_wr_req_i & (~a_wr_req_i |  prefer_b_q);
  assign wr_gnt = a_gnt | b_gnt;

  assign win_ad    = b_gnt ? b_wr_ad_i   : a_wr_ad_i;
  assign win_pair  = b_gnt ? b_wr_pair_i : a_wr_pair_i;
  assign win_val   = b_gnt ? b_wr_val_i  : a_wr_val_i;
  assign win_val2  = b_gnt ? b_wr_val2_i : a_wr_val2_i;
  assign win_ad_p1 = win_ad + 1'b1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    set_mask     = '0;
    clr_mask     = '0;
    prefer_b_d   = prefer_b_q;
    src1_ad_d    = src1_ad_q;
    src2_ad_d    = src2_ad_q;
    reg2_wr_en_d = 1'b0;
    out_ad_d     = out_ad_q;
    wrt_val_d    = wrt_val_q;
    wrt_val2_d   = wrt_val2_q;
    stall_cnt_d  = stall_cnt_q;

    if (rd_gnt) begin
      set_mask[rd_dst_i] = 1'b1;
      if (rd_pair_i) set_mask[dst_p1] = 1'b1;
      src1_ad_d = rd_src1_i;
      src2_ad_d = rd_src2_i;
    end

    if (wr_gnt) begin
      clr_mask[win_ad] = 1'b1;
      if (win_pair) clr_mask[win_ad_p1] = 1'b1;
      reg2_wr_en_d = win_pair;
      out_ad_d     = win_ad;
      wrt_val_d    = win_val;
      wrt_val2_d   = win_val2;
      // The next tie goes to the requester that was not just served.
      prefer_b_d   = a_gnt;
    end

    // Clear is applied before set, so a same-edge set of one bit wins.
    // Clearing a bit that is already 0 (host preload) has no effect.
    pend_d = flush_i ? '0 : ((pend_q & ~clr_mask) | set_mask);

    // The stall count also counts flush cycles, because flush forces rd_gnt low.
    if (rd_req_i && !rd_gnt && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the reset clears the data and address registers as well as the
    // control state, so the reg stack sees a defined bus after reset.
    if (!rst_ni) begin
      // NOTE: state is updated with non-blocking assignments only. Every
      // register then samples the values from before the edge, whatever the
      // order of the statements.
      pend_q       <= '0;
      stall_cnt_q  <= '0;
      prefer_b_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      src1_ad_q    <= '0;
      src2_ad_q    <= '0;
      wrt_en_q     <= 1'b0;
      reg2_wr_en_q <= 1'b0;
      out_ad_q     <= '0;
      wrt_val_q    <= '0;
      wrt_val2_q   <= '0;
    end else begin
      pend_q       <= pend_d;
      stall_cnt_q  <= stall_cnt_d;
      prefer_b_q   <= prefer_b_d;
      rd_en_q      <= rd_gnt;
      src1_ad_q    <= src1_ad_d;
      src2_ad_q    <= src2_ad_d;
      wrt_en_q     <= wr_gnt;
      reg2_wr_en_q <= reg2_wr_en_d;
      out_ad_q     <= out_ad_d;
      wrt_val_q    <= wrt_val_d;
      wrt_val2_q   <= wrt_val2_d;
    end
  end

  assign rd_gnt_o       = rd_gnt;
  assign a_wr_gnt_o     = a_gnt;
  assign b_wr_gnt_o     = b_gnt;
  assign rd_en_o        = rd_en_q;
  assign reg_src1_ad_o  = src1_ad_q;
  assign reg_src2_ad_o  = src2_ad_q;
  assign wrt_en_o       = wrt_en_q;
  assign reg2_wr_en_o   = reg2_wr_en_q;
  assign reg_out_ad_o   = out_ad_q;
  assign reg_wrt_val_o  = wrt_val_q;
  assign reg_wrt_val2_o = wrt_val2_q;
  assign pend_o         = pend_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_regfile_access_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_scheduler
//
// Directed bench for regfile_access_scheduler with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge. Combinational grants are
// sampled 1 ns after the inputs change. Registered outputs are sampled 1 ns
// after the next rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_access_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        rd_req_i, rd_pair_i;
  logic [3:0]  rd_src1_i, rd_src2_i, rd_dst_i;
  logic        a_wr_req_i, a_wr_pair_i;
  logic [3:0]  a_wr_ad_i;
  logic [31:0] a_wr_val_i, a_wr_val2_i;
  logic        b_wr_req_i, b_wr_pair_i;
  logic [3:0]  b_wr_ad_i;
  logic [31:0] b_wr_val_i, b_wr_val2_i;
  logic        rd_gnt_o, a_wr_gnt_o, b_wr_gnt_o;
  logic        rd_en_o, wrt_en_o, reg2_wr_en_o;
  logic [3:0]  reg_src1_ad_o, reg_src2_ad_o, reg_out_ad_o;
  logic [31:0] reg_wrt_val_o, reg_wrt_val2_o;
  logic [15:0] pend_o, stall_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  regfile_access_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .rd_req_i      (rd_req_i),
    .rd_src1_i     (rd_src1_i),
    .rd_src2_i     (rd_src2_i),
    .rd_dst_i      (rd_dst_i),
    .rd_pair_i     (rd_pair_i),
    .rd_gnt_o      (rd_gnt_o),
    .a_wr_req_i    (a_wr_req_i),
    .a_wr_ad_i     (a_wr_ad_i),
    .a_wr_pair_i   (a_wr_pair_i),
    .a_wr_val_i    (a_wr_val_i),
    .a_wr_val2_i   (a_wr_val2_i),
    .a_wr_gnt_o    (a_wr_gnt_o),
    .b_wr_req_i    (b_wr_req_i),
    .b_wr_ad_i     (b_wr_ad_i),
    .b_wr_pair_i   (b_wr_pair_i),
    .b_wr_val_i    (b_wr_val_i),
    .b_wr_val2_i   (b_wr_val2_i),
    .b_wr_gnt_o    (b_wr_gnt_o),
    .rd_en_o       (rd_en_o),
    .reg_src1_ad_o (reg_src1_ad_o),
    .reg_src2_ad_o (reg_src2_ad_o),
    .wrt_en_o      (wrt_en_o),
    .reg2_wr_en_o  (reg2_wr_en_o),
    .reg_out_ad_o  (reg_out_ad_o),
    .reg_wrt_val_o (reg_wrt_val_o),
    .reg_wrt_val2_o(reg_wrt_val2_o),
    .pend_o        (pend_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic req, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic pair);
    rd_req_i = req; rd_src1_i = s1; rd_src2_i = s2; rd_dst_i = d; rd_pair_i = pair;
  endtask

  task automatic wr_a(input logic req, input logic [3:0] ad, input logic pair,
                      input logic [31:0] v, input logic [31:0] v2);
    a_wr_req_i = req; a_wr_ad_i = ad; a_wr_pair_i = pair; a_wr_val_i = v; a_wr_val2_i = v2;
  endtask

  task automatic wr_b(input logic req, input logic [3:0] ad, input logic pair,
                      input logic [31:0] v, input logic [31:0] v2);
    b_wr_req_i = req; b_wr_ad_i = ad; b_wr_pair_i = pair; b_wr_val_i = v; b_wr_val2_i = v2;
  endtask

  initial begin
    logic exp_a;

    // ---- reset with every request high ----
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    issue(1'b1, 4'd0, 4'd0, 4'd1, 1'b0);
    wr_a(1'b1, 4'd2, 1'b0, 32'h1, 32'h0);
    wr_b(1'b1, 4'd3, 1'b0, 32'h2, 32'h0);
    #1;
    check("rst_rd_gnt", rd_gnt_o,   0);
    check("rst_a_gnt",  a_wr_gnt_o, 0);
    check("rst_b_gnt",  b_wr_gnt_o, 0);
    tick();
    tick();
    check("rst2_rd_gnt", rd_gnt_o,   0);
    check("rst2_a_gnt",  a_wr_gnt_o, 0);
    check("rst2_b_gnt",  b_wr_gnt_o, 0);
    check("rst_pend",    pend_o,     0);
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    wr_a(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    wr_b(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_pend",  pend_o,      0);
    check("post_rst_wrten", wrt_en_o,    0);
    check("post_rst_rden",  rd_en_o,     0);
    check("post_rst_stall", stall_cnt_o, 0);

    // ---- RAW stall: issue dst=3, then a dependent read of 3 ----
    issue(1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
    #1 check("iss3_gnt", rd_gnt_o, 1);
    tick();
    check("iss3_pend",  pend_o,        32'h0008);
    check("iss3_rden",  rd_en_o,       1);
    check("iss3_src1",  reg_src1_ad_o, 1);
    check("iss3_src2",  reg_src2_ad_o, 2);
    issue(1'b1, 4'd3, 4'd0, 4'd4, 1'b0);
    #1 check("raw_gnt0", rd_gnt_o, 0);
    tick();
    check("raw_stall1", stall_cnt_o, 1);
    check("raw_rden0",  rd_en_o,     0);
    check("raw_src1_hold", reg_src1_ad_o, 1);
    tick();
    check("raw_stall2", stall_cnt_o, 2);
    // A writes reg 3; the read is still blocked this cycle.
    wr_a(1'b1, 4'd3, 1'b0, 32'h0000_0011, 32'h0);
    #1;
    check("a3_gnt",      a_wr_gnt_o, 1);
    check("a3_rd_blk",   rd_gnt_o,   0);
    tick();
    check("a3_pend",     pend_o,        0);
    check("a3_wrten",    wrt_en_o,      1);
    check("a3_ad",       reg_out_ad_o,  3);
    check("a3_val",      reg_wrt_val_o, 32'h0000_0011);
    check("a3_reg2",     reg2_wr_en_o,  0);
    check("a3_stall3",   stall_cnt_o,   3);
    wr_a(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    #1 check("raw_gnt1", rd_gnt_o, 1);
    tick();
    check("raw_pend4",   pend_o,        32'h0010);
    check("raw_stall_h", stall_cnt_o,   3);
    check("raw_rden1",   rd_en_o,       1);
    check("raw_src1",    reg_src1_ad_o, 3);
    check("a_wrten_off", wrt_en_o,      0);
    check("a_ad_hold",   reg_out_ad_o,  3);
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

    // ---- pair wrap 15 -> 0 ----
    wr_b(1'b1, 4'd4, 1'b0, 32'h0, 32'h0);   // retire reg 4
    tick();
    check("b4_pend", pend_o, 0);
    wr_b(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    issue(1'b1, 4'd0, 4'd0, 4'd15, 1'b1);
    #1 check("iss15_gnt", rd_gnt_o, 1);
    tick();
    check("iss15_pend", pend_o, 32'h8001);
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    wr_b(1'b1, 4'd15, 1'b1, 32'h3F80_0000, 32'h4000_0000);
    #1 check("b15_gnt", b_wr_gnt_o, 1);
    tick();
    check("b15_ad",   reg_out_ad_o,   15);
    check("b15_reg2", reg2_wr_en_o,   1);
    check("b15_val",  reg_wrt_val_o,  32'h3F80_0000);
    check("b15_val2", reg_wrt_val2_o, 32'h4000_0000);
    check("b15_pend", pend_o,         0);
    check("b15_wren", wrt_en_o,       1);

    // ---- round robin: B served last, so A goes first ----
    wr_a(1'b1, 4'd6, 1'b0, 32'hAAAA_0006, 32'h0);
    wr_b(1'b1, 4'd7, 1'b0, 32'hBBBB_0007, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      check($sformatf("rr%0d_a", i), a_wr_gnt_o, {31'b0, exp_a});
      check($sformatf("rr%0d_b", i), b_wr_gnt_o, {31'b0, ~exp_a});
      tick();
      check($sformatf("rr%0d_wren", i), wrt_en_o, 1);
      check($sformatf("rr%0d_ad", i), reg_out_ad_o, exp_a ? 32'd6 : 32'd7);
      check($sformatf("rr%0d_val", i), reg_wrt_val_o, exp_a ? 32'hAAAA_0006 : 32'hBBBB_0007);
    end
    wr_a(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    wr_b(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rr_wren_off", wrt_en_o,     0);
    check("rr_reg2_off", reg2_wr_en_o, 0);

    // ---- same-edge set and clear of pend[5]: set wins ----
    issue(1'b1, 4'd0, 4'd0, 4'd5, 1'b0);
    wr_a(1'b1, 4'd5, 1'b0, 32'h5, 32'h0);
    #1;
    check("sc_rd_gnt", rd_gnt_o,   1);
    check("sc_a_gnt",  a_wr_gnt_o, 1);
    tick();
    check("sc_pend", pend_o, 32'h0020);
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    check("sc_clear", pend_o, 0);
    wr_a(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);

    // ---- build pend = 0x00F0, then flush ----
    issue(1'b1, 4'd0, 4'd0, 4'd4, 1'b1);
    tick();
    issue(1'b1, 4'd0, 4'd0, 4'd6, 1'b1);
    tick();
    check("fl_pend_pre", pend_o, 32'h00F0);
    issue(1'b1, 4'd0, 4'd0, 4'd8, 1'b0);
    wr_a(1'b1, 4'd4, 1'b0, 32'h4, 32'h0);
    flush_i = 1'b1;
    #1;
    check("fl_rd_gnt", rd_gnt_o,   0);
    check("fl_a_gnt",  a_wr_gnt_o, 0);
    check("fl_b_gnt",  b_wr_gnt_o, 0);
    tick();
    check("fl_pend",  pend_o,      0);
    check("fl_wren",  wrt_en_o,    0);
    check("fl_rden",  rd_en_o,     0);
    check("fl_stall", stall_cnt_o, 4);
    flush_i = 1'b0;
    wr_a(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);

    // ---- reset drops in-flight pend bits ----
    issue(1'b1, 4'd0, 4'd0, 4'd9, 1'b0);
    tick();
    check("ir_pend", pend_o, 32'h0200);
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    rst_ni = 1'b0;
    tick();
    check("ir_pend0",  pend_o,       0);
    check("ir_stall0", stall_cnt_o,  0);
    check("ir_ad0",    reg_out_ad_o, 0);
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
